// File: rtl/rv_muldiv_unit_if.sv
// Request/response bundle between an issuing stage and rv_muldiv_unit.
//   master: drives start, funct3, rs1_val, rs2_val, rd_in; observes the status and write-back.
//   slave : the execute unit; drives busy, done, wen, result, rd_out.
interface rv_muldiv_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [4:0]      rd_in;
  logic            busy;
  logic            done;
  logic            wen;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_out;

  modport master (
    output start, funct3, rs1_val, rs2_val, rd_in,
    input  busy, done, wen, result, rd_out
  );

  modport slave (
    input  start, funct3, rs1_val, rs2_val, rd_in,
    output busy, done, wen, result, rd_out
  );
endinterface

// File: rtl/rv_muldiv_unit.sv
// Iterative RV32M multiply/divide execute unit.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset; aborts any op in flight
//   bus   - request (start, funct3, rs1_val, rs2_val, rd_in) and write-back
//           (busy, done, wen, result, rd_out); result/rd_out/wen drive the rf write port.
// Each op takes exactly XLEN iterations (shift-add multiply or restoring divide, one bit per
// cycle) on operand magnitudes; the sign is applied when the final value is captured.
module rv_muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input logic            clk,
  input logic            rst_n,
  rv_muldiv_unit_if.slave bus
);

  localparam int unsigned CntW = $clog2(XLEN);
  localparam logic [CntW-1:0] CntLast = CntW'(XLEN - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  // {hi, lo}: multiply -> {partial product, remaining multiplier};
  //           divide   -> {partial remainder, dividend/quotient shift register}.
  logic [2*XLEN-1:0] acc_q, acc_d;
  // Multiplicand magnitude for multiplies, divisor magnitude for divides.
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [2:0]        f3_q, f3_d;
  logic              neg_a_q, neg_a_d;
  logic              neg_b_q, neg_b_d;
  logic [4:0]        rd_q, rd_d;
  logic [XLEN-1:0]   result_q, result_d;

  // Operand preparation at acceptance.
  logic            accept;
  logic            sgn_a, sgn_b;
  logic            neg_a_in, neg_b_in;
  logic [XLEN-1:0] mag_a, mag_b;

  // One iteration of the datapath.
  logic [XLEN-1:0]   hi, lo;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_shift, div_diff;
  logic [2*XLEN-1:0] div_next;
  logic [2*XLEN-1:0] iter_next;

  // Sign correction of the final iteration.
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   mul_res, quo, rem, quo_res, rem_res, fin;
  logic              div_by_zero;

  always_comb begin
    accept = bus.start && (state_q == StIdle || state_q == StDone);
    // MUL only needs the low half, so it is computed unsigned.
    sgn_a = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
            (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
    sgn_b = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
    neg_a_in = sgn_a && bus.rs1_val[XLEN-1];
    neg_b_in = sgn_b && bus.rs2_val[XLEN-1];
    mag_a = neg_a_in ? (~bus.rs1_val + 1'b1) : bus.rs1_val;
    mag_b = neg_b_in ? (~bus.rs2_val + 1'b1) : bus.rs2_val;
  end

  always_comb begin
    hi = acc_q[2*XLEN-1:XLEN];
    lo = acc_q[XLEN-1:0];

    mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
    mul_next = {mul_sum, lo[XLEN-1:1]};

    // Partial remainder stays below the divisor, so a failed trial fits in XLEN bits.
    div_shift = {hi, lo[XLEN-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    div_next  = div_diff[XLEN] ? {div_shift[XLEN-1:0], lo[XLEN-2:0], 1'b0}
                               : {div_diff[XLEN-1:0],  lo[XLEN-2:0], 1'b1};

    iter_next = f3_q[2] ? div_next : mul_next;
  end

  always_comb begin
    prod    = (neg_a_q ^ neg_b_q) ? (~iter_next + 1'b1) : iter_next;
    mul_res = (f3_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

    quo = iter_next[XLEN-1:0];
    rem = iter_next[2*XLEN-1:XLEN];
    div_by_zero = (opnd_q == '0);
    // A zero divisor yields an all-ones magnitude quotient; it must not be negated.
    quo_res = div_by_zero ? '1 : ((neg_a_q ^ neg_b_q) ? (~quo + 1'b1) : quo);
    rem_res = neg_a_q ? (~rem + 1'b1) : rem;

    fin = f3_q[2] ? (f3_q[1] ? rem_res : quo_res) : mul_res;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    f3_d     = f3_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    rd_d     = rd_q;
    result_d = result_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (accept) begin
          state_d = StRun;
          cnt_d   = '0;
          f3_d    = bus.funct3;
          neg_a_d = neg_a_in;
          neg_b_d = neg_b_in;
          rd_d    = bus.rd_in;
          if (bus.funct3[2]) begin
            opnd_d = mag_b;
            acc_d  = {{XLEN{1'b0}}, mag_a};
          end else begin
            opnd_d = mag_a;
            acc_d  = {{XLEN{1'b0}}, mag_b};
          end
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        acc_d = iter_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          state_d  = StDone;
          result_d = fin;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      f3_q     <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      rd_q     <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      f3_q     <= f3_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      rd_q     <= rd_d;
      result_q <= result_d;
    end
  end

  assign bus.busy   = (state_q == StRun);
  assign bus.done   = (state_q == StDone);
  assign bus.wen    = (state_q == StDone);
  assign bus.result = result_q;
  assign bus.rd_out = rd_q;

endmodule

// File: tb/tb_rv_muldiv_unit.sv
module tb_rv_muldiv_unit;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  rv_muldiv_unit_if #(.XLEN(32)) bus ();

  rv_muldiv_unit #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain wide arithmetic straight from the RV32M definition.
  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = (f == 3'b001 || f == 3'b010) ? {{32{a[31]}}, a} : {32'b0, a};
    eb = (f == 3'b001) ? {{32{b[31]}}, b} : {32'b0, b};
    p  = ea * eb;
    case (f)
      3'b000: return p[31:0];
      3'b001, 3'b010, 3'b011: return p[63:32];
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'($signed(a) / $signed(b));
      end
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'($signed(a) % $signed(b));
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Called just after a negedge; returns just after the negedge following the accepting edge.
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    bus.funct3  = f;
    bus.rs1_val = a;
    bus.rs2_val = b;
    bus.rd_in   = rd;
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start   = 1'b0;
    // Operands are only sampled at acceptance; scramble them afterwards.
    bus.rs1_val = $urandom;
    bus.rs2_val = $urandom;
    bus.funct3  = 3'($urandom);
    bus.rd_in   = 5'($urandom);
  endtask

  // Waits for done, checking latency, busy length and write-back. ign_at > 0 pulses a stray
  // start at that RUN cycle. chk_pulse checks that done drops on the next cycle.
  task automatic finish_op(input string tag, input logic [31:0] expv, input logic [4:0] rd,
                           input int ign_at, input bit chk_pulse);
    int n      = 1;
    int busy_n = 0;
    while (!bus.done && n <= 100) begin
      if (bus.busy) busy_n++;
      if (n == ign_at) begin
        bus.start   = 1'b1;
        bus.rs1_val = $urandom;
        bus.rs2_val = $urandom;
        bus.rd_in   = 5'($urandom);
      end else if (n == ign_at + 1) begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    bus.start = 1'b0;
    check_eq({tag, ".latency"}, 64'(n - 1), 64'd32);
    check_eq({tag, ".busy_cycles"}, 64'(busy_n), 64'd32);
    check_eq({tag, ".result"}, 64'(bus.result), 64'(expv));
    check_eq({tag, ".rd_out"}, 64'(bus.rd_out), 64'(rd));
    check_eq({tag, ".wen"}, 64'(bus.wen), 64'd1);
    if (chk_pulse) begin
      @(negedge clk);
      check_eq({tag, ".done_pulse"}, 64'({bus.done, bus.wen, bus.busy}), 64'd0);
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd);
    issue(f, a, b, rd);
    finish_op(tag, ref_model(f, a, b), rd, 0, 1'b1);
  endtask

  logic [31:0] specials [6];
  logic [31:0] ra, rb;
  logic [2:0]  rf;
  logic [4:0]  rrd;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    specials = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h2};
    rst_n       = 1'b0;
    bus.start   = 1'b0;
    bus.funct3  = '0;
    bus.rs1_val = '0;
    bus.rs2_val = '0;
    bus.rd_in   = '0;
    repeat (3) @(negedge clk);
    check_eq("reset.outputs", 64'({bus.busy, bus.done, bus.wen, bus.rd_out, bus.result}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // MUL 7x6 with hold check.
    issue(3'b000, 32'd7, 32'd6, 5'd5);
    finish_op("mul7x6", 32'd42, 5'd5, 0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("mul7x6.hold", 64'({bus.done, bus.result}), 64'd42);
    end

    run_op("mulh_min",   3'b001, 32'h8000_0000, 32'h8000_0000, 5'd1);
    check_eq("mulh_min.val", 64'(bus.result), 64'h4000_0000);
    run_op("mulhu_max",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
    check_eq("mulhu_max.val", 64'(bus.result), 64'hFFFF_FFFE);
    run_op("mulhsu",     3'b010, 32'hFFFF_FFFF, 32'd2, 5'd3);
    check_eq("mulhsu.val", 64'(bus.result), 64'hFFFF_FFFF);
    run_op("mul_max",    3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4);
    check_eq("mul_max.val", 64'(bus.result), 64'h1);
    run_op("div_m7_2",   3'b100, 32'hFFFF_FFF9, 32'd2, 5'd6);
    check_eq("div_m7_2.val", 64'(bus.result), 64'hFFFF_FFFD);
    run_op("rem_m7_2",   3'b110, 32'hFFFF_FFF9, 32'd2, 5'd7);
    check_eq("rem_m7_2.val", 64'(bus.result), 64'hFFFF_FFFF);
    run_op("divu_100_7", 3'b101, 32'd100, 32'd7, 5'd8);
    check_eq("divu_100_7.val", 64'(bus.result), 64'd14);
    run_op("remu_100_7", 3'b111, 32'd100, 32'd7, 5'd9);
    check_eq("remu_100_7.val", 64'(bus.result), 64'd2);
    run_op("div_7_m2",   3'b100, 32'd7, 32'hFFFF_FFFE, 5'd10);
    check_eq("div_7_m2.val", 64'(bus.result), 64'hFFFF_FFFD);
    run_op("rem_7_m2",   3'b110, 32'd7, 32'hFFFF_FFFE, 5'd11);
    check_eq("rem_7_m2.val", 64'(bus.result), 64'd1);
    run_op("divu_by0",   3'b101, 32'd5, 32'd0, 5'd12);
    check_eq("divu_by0.val", 64'(bus.result), 64'hFFFF_FFFF);
    run_op("remu_by0",   3'b111, 32'd5, 32'd0, 5'd13);
    check_eq("remu_by0.val", 64'(bus.result), 64'd5);
    run_op("div_ovf",    3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14);
    check_eq("div_ovf.val", 64'(bus.result), 64'h8000_0000);
    run_op("rem_ovf",    3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15);
    check_eq("rem_ovf.val", 64'(bus.result), 64'd0);
    run_op("div_m5_by0", 3'b100, 32'hFFFF_FFFB, 32'd0, 5'd16);
    run_op("rem_m5_by0", 3'b110, 32'hFFFF_FFFB, 32'd0, 5'd17);

    // Reset mid-operation: outputs clear without a clock edge, no write-back follows.
    run_op("pre_rst", 3'b000, 32'd9, 32'd9, 5'd20);
    issue(3'b000, 32'd1234, 32'd5678, 5'd21);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid.outputs",
             64'({bus.busy, bus.done, bus.wen, bus.rd_out, bus.result}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int seen = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (bus.done || bus.busy) seen++;
      end
      check_eq("rst_mid.no_writeback", 64'(seen), 64'd0);
    end
    run_op("mul3x5", 3'b000, 32'd3, 32'd5, 5'd22);
    check_eq("mul3x5.val", 64'(bus.result), 64'd15);

    // Stray start during RUN is ignored.
    issue(3'b101, 32'd1000, 32'd10, 5'd23);
    finish_op("ignore_start", 32'd100, 5'd23, 5, 1'b1);

    // Back-to-back: start held high through DONE with DIVU 9/3 presented.
    bus.funct3  = 3'b000;
    bus.rs1_val = 32'd7;
    bus.rs2_val = 32'd6;
    bus.rd_in   = 5'd24;
    bus.start   = 1'b1;
    @(negedge clk);
    bus.funct3  = 3'b101;
    bus.rs1_val = 32'd9;
    bus.rs2_val = 32'd3;
    bus.rd_in   = 5'd25;
    begin
      int n = 1;
      while (!bus.done && n <= 100) begin
        @(negedge clk);
        n++;
      end
      check_eq("b2b.first_latency", 64'(n - 1), 64'd32);
      check_eq("b2b.first_result", 64'(bus.result), 64'd42);
      check_eq("b2b.first_rd", 64'(bus.rd_out), 64'd24);
    end
    @(negedge clk);
    bus.start = 1'b0;
    check_eq("b2b.accepted", 64'(bus.busy), 64'd1);
    finish_op("b2b.second", 32'd3, 5'd25, 0, 1'b1);

    // Randomized ops, operands biased toward boundary values.
    for (int i = 0; i < 40; i++) begin
      rf  = 3'($urandom);
      ra  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] :
            (($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 300)) : $urandom);
      rrd = 5'($urandom);
      run_op($sformatf("rand%0d_f%0d", i, rf), rf, ra, rb, rrd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the bench always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1);
  end

endmodule
